// File: rtl/bp_pkg.sv
// Shared types and helpers for the PC-indexed pattern history table predictor.
// Holds the sweep FSM state type and counter saturation limits.
package bp_pkg;

    typedef enum logic {
        BP_INIT = 1'b0,
        BP_RUN  = 1'b1
    } bp_state_e;

    localparam int CTR_MIN = 0;

    function automatic int bp_clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int ctr_max(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/branch_predictor_pht_if.sv
// Lookup (ID stage) and resolution (EX stage) bundle between the pipeline and the PHT.
// The pipeline side is the master; the predictor is the slave.
interface branch_predictor_pht_if #(
    parameter int PC_W  = 32,
    parameter int IDX_W = 6
);
    logic [PC_W-1:0]  lookup_pc;
    logic             predict;
    logic [IDX_W-1:0] predict_idx;
    logic             update_valid;
    logic [IDX_W-1:0] update_idx;
    logic             update_taken;
    logic             update_mispred;

    modport master (
        output lookup_pc, update_valid, update_idx, update_taken, update_mispred,
        input  predict, predict_idx
    );

    modport slave (
        input  lookup_pc, update_valid, update_idx, update_taken, update_mispred,
        output predict, predict_idx
    );
endinterface

// File: rtl/bp_sat_ctr.sv
// Next-value logic for one CTR_W-bit saturating up/down counter.
module bp_sat_ctr
    import bp_pkg::*;
#(
    parameter int CTR_W = 2
)(
    input  logic [CTR_W-1:0] cur_ctr,
    input  logic             taken,
    output logic [CTR_W-1:0] next_ctr
);
    localparam logic [CTR_W-1:0] MAX_VAL = CTR_W'(ctr_max(CTR_W));
    localparam logic [CTR_W-1:0] MIN_VAL = CTR_W'(CTR_MIN);

    always_comb begin
        next_ctr = cur_ctr;
        if (taken) begin
            if (cur_ctr != MAX_VAL) begin
                next_ctr = cur_ctr + CTR_W'(1);
            end
        end else if (cur_ctr != MIN_VAL) begin
            next_ctr = cur_ctr - CTR_W'(1);
        end
    end
endmodule

// File: rtl/branch_predictor_pht.sv
// PC-indexed pattern history table of saturating counters with an init sweep and perf counters.
// Define BP_GSHARE_EN to XOR a non-speculative global history register into the index.
module branch_predictor_pht
    import bp_pkg::*;
#(
    parameter int ENTRIES  = 64,
    parameter int CTR_W    = 2,
    parameter int CTR_INIT = 2,
    parameter int PC_W     = 32,
    parameter int GHR_W    = 6,
    parameter int STAT_W   = 32
)(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    branch_predictor_pht_if.slave bus,
    output logic                  ready_o,
    output logic [STAT_W-1:0]     stat_branches_o,
    output logic [STAT_W-1:0]     stat_mispred_o
);
    localparam int IDX_W = bp_clog2(ENTRIES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    bp_state_e        state;
    bp_state_e        state_next;
    logic [IDX_W-1:0] sweep_ptr;
    logic [CTR_W-1:0] pht [0:ENTRIES-1];
    logic [IDX_W-1:0] pc_idx;
    logic [IDX_W-1:0] lookup_idx;
    logic [CTR_W-1:0] ctr_next;
    logic             pht_we;
    logic [IDX_W-1:0] pht_wr_idx;
    logic [CTR_W-1:0] pht_wr_data;
    logic             unused_pc_bits;

    assign pc_idx         = bus.lookup_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{bus.lookup_pc[PC_W-1:IDX_W+2], bus.lookup_pc[1:0]};

`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0] ghr;

    // History follows resolution order, so it only advances on updates the table accepts.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ghr <= '0;
        end else if (clear_i) begin
            ghr <= '0;
        end else if (state == BP_RUN && bus.update_valid) begin
            ghr <= GHR_W'({ghr, bus.update_taken});
        end
    end

    assign lookup_idx = pc_idx ^ IDX_W'(ghr);
`else
    localparam int unused_ghr_w = GHR_W;
    assign lookup_idx = pc_idx;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state     <= BP_INIT;
            sweep_ptr <= '0;
        end else begin
            state <= state_next;
            if (clear_i || state == BP_RUN || sweep_ptr == LAST_IDX) begin
                sweep_ptr <= '0;
            end else begin
                sweep_ptr <= sweep_ptr + IDX_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        if (clear_i) begin
            state_next = BP_INIT;
        end else if (state == BP_INIT && sweep_ptr == LAST_IDX) begin
            state_next = BP_RUN;
        end
    end

    // A clear in the same cycle as a resolution drops the update.
    always_comb begin
        ready_o     = 1'b0;
        pht_we      = 1'b0;
        pht_wr_idx  = bus.update_idx;
        pht_wr_data = ctr_next;
        if (state == BP_INIT) begin
            pht_we      = 1'b1;
            pht_wr_idx  = sweep_ptr;
            pht_wr_data = CTR_W'(CTR_INIT);
        end else begin
            ready_o = 1'b1;
            pht_we  = bus.update_valid && !clear_i;
        end
    end

    bp_sat_ctr #(.CTR_W(CTR_W)) u_sat_ctr (
        .cur_ctr  (pht[bus.update_idx]),
        .taken    (bus.update_taken),
        .next_ctr (ctr_next)
    );

    always_ff @(posedge clk_i) begin
        if (pht_we) begin
            pht[pht_wr_idx] <= pht_wr_data;
        end
    end

    assign bus.predict_idx = lookup_idx;
    assign bus.predict     = ready_o & pht[lookup_idx][CTR_W-1];

    // Perf counters keep counting through the sweep and survive clear_i.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stat_branches_o <= '0;
            stat_mispred_o  <= '0;
        end else if (bus.update_valid) begin
            if (stat_branches_o != '1) begin
                stat_branches_o <= stat_branches_o + STAT_W'(1);
            end
            if (bus.update_mispred && stat_mispred_o != '1) begin
                stat_mispred_o <= stat_mispred_o + STAT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor_pht.sv
// Directed self-checking bench for branch_predictor_pht (default 64-entry, 2-bit build).
// With BP_GSHARE_EN defined the bench tracks the expected history to pick lookup PCs.
module tb_branch_predictor_pht;
    import bp_pkg::*;

    localparam int ENTRIES = 64;
    localparam int CTR_W   = 2;
    localparam int PC_W    = 32;
    localparam int IDX_W   = 6;
    localparam int GHR_W   = 6;
    localparam int STAT_W  = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear;
    logic              ready;
    logic [STAT_W-1:0] stat_br;
    logic [STAT_W-1:0] stat_mis;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_branches = 0;
    int exp_mispred  = 0;

`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0] exp_ghr = '0;
`endif

    branch_predictor_pht_if #(.PC_W(PC_W), .IDX_W(IDX_W)) bus ();

    branch_predictor_pht #(
        .ENTRIES  (ENTRIES),
        .CTR_W    (CTR_W),
        .CTR_INIT (2),
        .PC_W     (PC_W),
        .GHR_W    (GHR_W),
        .STAT_W   (STAT_W)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_n),
        .clear_i         (clear),
        .bus             (bus),
        .ready_o         (ready),
        .stat_branches_o (stat_br),
        .stat_mispred_o  (stat_mis)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // PC whose lookup lands on table entry idx given the expected history.
    function automatic logic [PC_W-1:0] pc_for(input int idx);
`ifdef BP_GSHARE_EN
        return PC_W'(idx ^ int'(exp_ghr)) << 2;
`else
        return PC_W'(idx) << 2;
`endif
    endfunction

    task automatic do_update(input int idx, input logic taken, input logic mispred);
        bus.update_valid   = 1'b1;
        bus.update_idx     = IDX_W'(idx);
        bus.update_taken   = taken;
        bus.update_mispred = mispred;
        step();
        bus.update_valid   = 1'b0;
        exp_branches++;
        if (mispred) exp_mispred++;
`ifdef BP_GSHARE_EN
        exp_ghr = {exp_ghr[GHR_W-2:0], taken};
`endif
    endtask

    task automatic test_reset();
        int cnt;
        logic [PC_W-1:0] pcs [4];
        logic [IDX_W-1:0] idxs [4];
        pcs  = '{32'h0000_0000, 32'h0000_0014, 32'h0000_00FC, 32'h1234_5678};
        idxs = '{6'h00, 6'h05, 6'h3F, 6'h1E};
        rst_n = 1'b0;
        clear = 1'b0;
        bus.lookup_pc      = 32'h14;
        bus.update_valid   = 1'b0;
        bus.update_idx     = '0;
        bus.update_taken   = 1'b0;
        bus.update_mispred = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        tests_run++;
        if (ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ready: got %0b want 0", ready);
        end
        tests_run++;
        if (bus.predict !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_predict: got %0b want 0", bus.predict);
        end
        tests_run++;
        if (stat_br !== '0 || stat_mis !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_stats: got %0d/%0d want 0/0", stat_br, stat_mis);
        end
        cnt = 0;
        while (ready !== 1'b1 && cnt < 200) begin
            step();
            cnt++;
            if (cnt == 32) begin
                tests_run++;
                if (bus.predict !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL init_predict: got %0b want 0", bus.predict);
                end
            end
        end
        tests_run++;
        if (cnt != 64) begin
            tests_failed++;
            $display("[TB] FAIL init_sweep_len: got %0d cycles want 64", cnt);
        end
        for (int i = 0; i < 4; i++) begin
            bus.lookup_pc = pcs[i];
            #1;
            tests_run++;
            if (bus.predict !== 1'b1 || bus.predict_idx !== idxs[i]) begin
                tests_failed++;
                $display("[TB] FAIL default_lookup pc=%h: got pred %0b idx %h want 1 idx %h",
                         pcs[i], bus.predict, bus.predict_idx, idxs[i]);
            end
        end
    endtask

    task automatic test_not_taken();
        logic exp_pred [3];
        exp_pred = '{1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            do_update(5, 1'b0, (i == 0));
            bus.lookup_pc = pc_for(5);
            #1;
            tests_run++;
            if (bus.predict !== exp_pred[i]) begin
                tests_failed++;
                $display("[TB] FAIL not_taken_%0d: got %0b want %0b", i, bus.predict, exp_pred[i]);
            end
        end
    endtask

    task automatic test_taken();
        logic exp_pred [5];
        logic taken [5];
        logic mis [5];
        exp_pred = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        taken    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        mis      = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            do_update(5, taken[i], mis[i]);
            bus.lookup_pc = pc_for(5);
            #1;
            tests_run++;
            if (bus.predict !== exp_pred[i]) begin
                tests_failed++;
                $display("[TB] FAIL taken_%0d: got %0b want %0b", i, bus.predict, exp_pred[i]);
            end
        end
        bus.lookup_pc = pc_for(6);
        #1;
        tests_run++;
        if (bus.predict !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL neighbour_idx6: got %0b want 1", bus.predict);
        end
        tests_run++;
        if (stat_br !== STAT_W'(exp_branches) || stat_mis !== STAT_W'(exp_mispred)) begin
            tests_failed++;
            $display("[TB] FAIL stats_run: got %0d/%0d want %0d/%0d",
                     stat_br, stat_mis, exp_branches, exp_mispred);
        end
    endtask

    task automatic test_same_cycle();
        bus.lookup_pc      = pc_for(5);
        bus.update_valid   = 1'b1;
        bus.update_idx     = 6'd5;
        bus.update_taken   = 1'b0;
        bus.update_mispred = 1'b1;
        #1;
        tests_run++;
        if (bus.predict !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL same_cycle_pre: got %0b want 1", bus.predict);
        end
        step();
        bus.update_valid = 1'b0;
        exp_branches++;
        exp_mispred++;
`ifdef BP_GSHARE_EN
        exp_ghr = {exp_ghr[GHR_W-2:0], 1'b0};
`endif
        bus.lookup_pc = pc_for(5);
        #1;
        tests_run++;
        if (bus.predict !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL same_cycle_post: got %0b want 0", bus.predict);
        end
    endtask

    task automatic test_clear();
        int cnt;
        do_update(7, 1'b0, 1'b1);
        do_update(7, 1'b0, 1'b0);
        bus.lookup_pc = pc_for(7);
        #1;
        tests_run++;
        if (bus.predict !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL pre_clear_idx7: got %0b want 0", bus.predict);
        end
        clear              = 1'b1;
        bus.update_valid   = 1'b1;
        bus.update_idx     = 6'd7;
        bus.update_taken   = 1'b1;
        bus.update_mispred = 1'b0;
        step();
        clear            = 1'b0;
        bus.update_valid = 1'b0;
        exp_branches++;
`ifdef BP_GSHARE_EN
        exp_ghr = '0;
`endif
        bus.lookup_pc = 32'h18;
        cnt = 0;
        // Updates to entry 0 after the sweep passed it must be ignored.
        while (ready !== 1'b1 && cnt < 200) begin
            bus.update_valid   = (cnt == 10 || cnt == 11);
            bus.update_idx     = 6'd0;
            bus.update_taken   = 1'b0;
            bus.update_mispred = 1'b1;
            if (cnt == 10 || cnt == 11) begin
                exp_branches++;
                exp_mispred++;
            end
            if (cnt == 20) begin
                tests_run++;
                if (bus.predict !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL clear_sweep_predict: got %0b want 0", bus.predict);
                end
            end
            step();
            cnt++;
        end
        bus.update_valid = 1'b0;
        tests_run++;
        if (cnt != 64) begin
            tests_failed++;
            $display("[TB] FAIL clear_sweep_len: got %0d cycles want 64", cnt);
        end
        for (int i = 0; i < ENTRIES; i++) begin
            bus.lookup_pc = pc_for(i);
            #1;
            tests_run++;
            if (bus.predict !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL clear_entry_%0d: got %0b want 1", i, bus.predict);
            end
        end
        tests_run++;
        if (stat_br !== STAT_W'(exp_branches) || stat_mis !== STAT_W'(exp_mispred)) begin
            tests_failed++;
            $display("[TB] FAIL stats_after_clear: got %0d/%0d want %0d/%0d",
                     stat_br, stat_mis, exp_branches, exp_mispred);
        end
    endtask

    task automatic test_index();
`ifdef BP_GSHARE_EN
        do_update(1, 1'b1, 1'b0);
        do_update(1, 1'b1, 1'b0);
        do_update(1, 1'b0, 1'b1);
        bus.lookup_pc = 32'h40;
        #1;
        tests_run++;
        if (bus.predict_idx !== 6'h16) begin
            tests_failed++;
            $display("[TB] FAIL gshare_idx: got %h want 16", bus.predict_idx);
        end
`else
        do_update(1, 1'b1, 1'b0);
        bus.lookup_pc = 32'h40;
        #1;
        tests_run++;
        if (bus.predict_idx !== 6'h10) begin
            tests_failed++;
            $display("[TB] FAIL pc_idx: got %h want 10", bus.predict_idx);
        end
`endif
    endtask

    task automatic test_reset_midrun();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_branches = 0;
        exp_mispred  = 0;
`ifdef BP_GSHARE_EN
        exp_ghr = '0;
`endif
        bus.lookup_pc = 32'h14;
        #1;
        tests_run++;
        if (ready !== 1'b0 || bus.predict !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midrun_reset: got ready %0b pred %0b want 0 0", ready, bus.predict);
        end
        tests_run++;
        if (stat_br !== '0 || stat_mis !== '0) begin
            tests_failed++;
            $display("[TB] FAIL midrun_reset_stats: got %0d/%0d want 0/0", stat_br, stat_mis);
        end
    endtask

    initial begin
        test_reset();
        test_not_taken();
        test_taken();
        test_same_cycle();
        test_clear();
        test_index();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
